ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_arb_pkg.sv | 15 +
 rtl/sp_ram_sync.sv | 32 +++
 rtl/ram_port_arbiter.sv | 124 ++++++++++++
 tb/tb_ram_port_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and default sizes for the two-port RAM arbiter.
package ram_arb_pkg;

  localparam int unsigned DefAddrW    = 6;
  localparam int unsigned DefDataW    = 16;
  localparam int unsigned DefMaxBurst = 4;
  localparam int unsigned CntW        = 4;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StOwn0 = 2'b01,
    StOwn1 = 2'b10
  } arb_state_e;

endpackage

// File: rtl/sp_ram_sync.sv
// Single-port synchronous RAM; read address is registered, so a write is visible
// to a read of the same word on the following cycle.
module sp_ram_sync import ram_arb_pkg::*; #(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [Depth];
  logic [ADDR_W-1:0] addr_q;

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end
      addr_q <= addr;
    end
  end

  assign rdata = mem[addr_q];

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter in front of a single-port RAM with burst-limited
// ownership and a one-cycle read response tagged to the requester.
module ram_port_arbiter import ram_arb_pkg::*; #(
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned MAX_BURST = DefMaxBurst
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        owner
);

  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_BURST);

  arb_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            last_q, last_d;
  logic            rsp0_q, rsp1_q;
  logic            gnt0, gnt1;

  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state_q)
      StIdle: begin
        if (req0_valid && req1_valid) begin
          // last_q == 1 means req1 was served last, so req0 wins the tie.
          gnt0 = last_q;
          gnt1 = !last_q;
        end else begin
          gnt0 = req0_valid;
          gnt1 = req1_valid;
        end
      end
      StOwn0: begin
        if (req0_valid && !(cnt_q == MaxCnt && req1_valid)) gnt0 = 1'b1;
        else gnt1 = req1_valid;
      end
      StOwn1: begin
        if (req1_valid && !(cnt_q == MaxCnt && req0_valid)) gnt1 = 1'b1;
        else gnt0 = req0_valid;
      end
      default: ;
    endcase
    if (!RST_N) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  always_comb begin
    state_d = StIdle;
    cnt_d   = '0;
    last_d  = last_q;
    if (gnt0) begin
      state_d = StOwn0;
      last_d  = 1'b0;
      cnt_d   = (state_q != StOwn0) ? CntW'(1) :
                (cnt_q >= MaxCnt)   ? MaxCnt  : cnt_q + CntW'(1);
    end else if (gnt1) begin
      state_d = StOwn1;
      last_d  = 1'b1;
      cnt_d   = (state_q != StOwn1) ? CntW'(1) :
                (cnt_q >= MaxCnt)   ? MaxCnt  : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      rsp0_q  <= 1'b0;
      rsp1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      rsp0_q  <= gnt0 && !req0_we;
      rsp1_q  <= gnt1 && !req1_we;
    end
  end

  assign ram_en    = gnt0 || gnt1;
  assign ram_we    = gnt0 ? req0_we    : req1_we;
  assign ram_addr  = gnt0 ? req0_addr  : req1_addr;
  assign ram_wdata = gnt0 ? req0_wdata : req1_wdata;

  sp_ram_sync #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk  (CLK),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(rdata)
  );

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rsp0_valid = rsp0_q;
  assign rsp1_valid = rsp1_q;
  assign owner      = state_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a per-cycle reference model plus directed scenarios
// with literal expectations.
module tb_ram_port_arbiter;

  localparam int AW = 6;
  localparam int DW = 16;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid, req0_we, req1_valid, req1_we;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_wdata, req1_wdata;
  logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [DW-1:0] rdata;
  logic [1:0]    owner;

  int checks = 0;
  int failures = 0;
  bit checking = 1'b0;

  ram_port_arbiter #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .MAX_BURST(MB)
  ) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .req0_valid(req0_valid),
    .req0_we   (req0_we),
    .req0_addr (req0_addr),
    .req0_wdata(req0_wdata),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_we   (req1_we),
    .req1_addr (req1_addr),
    .req1_wdata(req1_wdata),
    .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid),
    .rsp1_valid(rsp1_valid),
    .rdata     (rdata),
    .owner     (owner)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner -1 = idle, else requester index; run = beats in current run.
  int            m_st = -1;
  int            m_cnt = 0;
  int            m_last = 1;
  int            m_rsp = -1;
  logic [DW-1:0] m_mem [64];
  bit            m_known [64];
  logic [DW-1:0] m_rdata;
  bit            m_rknown = 1'b0;

  function automatic int exp_grant(input bit v0, input bit v1);
    bit own_v, oth_v;
    if (m_st < 0) begin
      if (v0 && v1) return (m_last == 0) ? 1 : 0;
      if (v0) return 0;
      if (v1) return 1;
      return -1;
    end
    own_v = (m_st == 0) ? v0 : v1;
    oth_v = (m_st == 0) ? v1 : v0;
    if (own_v && !(m_cnt == MB && oth_v)) return m_st;
    if (oth_v) return 1 - m_st;
    return -1;
  endfunction

  task model_beat(input int g, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_cnt  <= (m_st == g) ? ((m_cnt < MB) ? m_cnt + 1 : MB) : 1;
    m_st   <= g;
    m_last <= g;
    if (we) begin
      m_mem[a]   <= d;
      m_known[a] <= 1'b1;
      m_rsp      <= -1;
    end else begin
      m_rsp    <= g;
      m_rdata  <= m_mem[a];
      m_rknown <= m_known[a];
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st   <= -1;
      m_cnt  <= 0;
      m_last <= 1;
      m_rsp  <= -1;
    end else begin
      case (exp_grant(req0_valid, req1_valid))
        0:       model_beat(0, req0_we, req0_addr, req0_wdata);
        1:       model_beat(1, req1_we, req1_addr, req1_wdata);
        default: begin
          m_st  <= -1;
          m_cnt <= 0;
          m_rsp <= -1;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    int g;
    if (checking) begin
      g = rst_n ? exp_grant(req0_valid, req1_valid) : -1;
      check("ready0", 32'(req0_ready), 32'(g == 0));
      check("ready1", 32'(req1_ready), 32'(g == 1));
      check("owner", 32'(owner), 32'(m_st + 1));
      check("rsp0_valid", 32'(rsp0_valid), 32'(m_rsp == 0));
      check("rsp1_valid", 32'(rsp1_valid), 32'(m_rsp == 1));
      if (m_rsp >= 0 && m_rknown) check("rdata", 32'(rdata), 32'(m_rdata));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input bit v, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
  endtask

  task automatic set1(input bit v, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
  endtask

  task automatic idle();
    set0(1'b0, 1'b0, '0, '0);
    set1(1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    logic [11:0] pat;
    int          hold;
    idle();
    repeat (3) @(posedge clk);
    #1;
    checking = 1'b1;
    set0(1'b1, 1'b0, 6'd3, '0);
    #1;
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    step();
    idle();
    rst_n = 1'b1;
    step();

    // Solo write then read.
    set0(1'b1, 1'b1, 6'd5, 16'hBEEF);
    step();
    set0(1'b1, 1'b0, 6'd5, '0);
    #1;
    check("solo_rd_ready0", 32'(req0_ready), 32'd1);
    step();
    idle();
    check("solo_rsp0", 32'(rsp0_valid), 32'd1);
    check("solo_rdata", 32'(rdata), 32'hBEEF);
    check("solo_rsp1", 32'(rsp1_valid), 32'd0);
    step();
    check("solo_rsp0_once", 32'(rsp0_valid), 32'd0);

    // Preload, then reset: contents must survive.
    for (int i = 0; i < 12; i++) begin
      set0(1'b1, 1'b1, AW'(i), DW'(16'hA000 + i));
      step();
    end
    idle();
    for (int i = 0; i < 12; i++) begin
      set1(1'b1, 1'b1, AW'(32 + i), DW'(16'hB000 + i));
      step();
    end
    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    // First tie after reset, then burst alternation.
    for (int i = 0; i < 12; i++) begin
      set0(1'b1, 1'b0, AW'(i), '0);
      set1(1'b1, 1'b0, AW'(32 + i), '0);
      #1;
      pat[11 - i] = req1_ready;
      check("one_grant", 32'(int'(req0_ready) + int'(req1_ready)), 32'd1);
      if (i == 0) begin
        check("tie_ready0", 32'(req0_ready), 32'd1);
        check("tie_ready1", 32'(req1_ready), 32'd0);
      end
      step();
      if (i == 0) check("tie_owner", 32'(owner), 32'd1);
    end
    check("burst_pattern", 32'(pat), 32'(12'b0000_1111_0000));
    idle();
    step();
    step();

    // req1 alone keeps ownership; saturated count lets req0 in at once.
    hold = 0;
    for (int i = 0; i < 10; i++) begin
      set1(1'b1, 1'b0, AW'(40 + i), '0);
      #1;
      hold += int'(req1_ready);
      step();
    end
    check("hold_beats", 32'(hold), 32'd10);
    set0(1'b1, 1'b0, 6'd1, '0);
    #1;
    check("sat_yield", 32'(req0_ready), 32'd1);
    step();
    idle();
    step();
    step();

    // Write by req0, read of same word by req1 on the next cycle.
    set0(1'b1, 1'b1, 6'd63, 16'h1234);
    step();
    idle();
    set1(1'b1, 1'b0, 6'd63, '0);
    step();
    idle();
    check("xw_rsp1", 32'(rsp1_valid), 32'd1);
    check("xw_rdata", 32'(rdata), 32'h1234);
    check("xw_rsp0", 32'(rsp0_valid), 32'd0);
    step();

    // Reset in the cycle after a granted read discards the response.
    set0(1'b1, 1'b0, 6'd5, '0);
    step();
    rst_n = 1'b0;
    idle();
    #1;
    check("mid_rst_rsp0", 32'(rsp0_valid), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_rsp0", 32'(rsp0_valid), 32'd0);
    check("post_rst_owner", 32'(owner), 32'd0);
    step();
    check("post_rst_rsp0_late", 32'(rsp0_valid), 32'd0);

    checking = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
